// File: rtl/silife_scan_capture.sv
// silife_scan_capture
//   Receiving end of the silife LED-matrix scan interface. Watches the rows /
//   columns lines driven by the scan driver, rebuilds the displayed
//   WIDTH x WIDTH frame into a shadow buffer and swaps it into the front
//   buffer once a complete, in-order 0..WIDTH-1 scan has been seen.
//   Malformed (multi-hot) or out-of-order scans raise a sticky sync_error.
//
// Ports
//   clk          in   system clock, rising edge
//   reset_n      in   asynchronous active-low reset
//   rows         in   [WIDTH]   one-hot row drive, 0 = blank
//   columns      in   [WIDTH]   column data for the active row
//   invert       in   columns are driven inverted; captured data is XORed back
//   clear_error  in   synchronous clear of sync_error
//   read_row     in   [IW]      front buffer read address
//   read_cells   out  [WIDTH]   front buffer row read_row (combinational)
//   frame_valid  out  one-cycle pulse after a frame reaches the front buffer
//   sync_error   out  sticky malformed / out-of-order scan flag
//
// Optional feature (macro SILIFE_SCAN_CAPTURE_STATS_EN)
//   frame_count  out  [16] frames delivered, wraps
//   error_count  out  [8]  error events, saturates at 8'hFF

module silife_scan_capture #(
    parameter int WIDTH         = 8,
    parameter int STABLE_CYCLES = 2,
    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1,
    localparam int CW = $clog2(STABLE_CYCLES + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] rows,
    input  logic [WIDTH-1:0] columns,
    input  logic             invert,
    input  logic             clear_error,
    input  logic [IW-1:0]    read_row,
    output logic [WIDTH-1:0] read_cells,
    output logic             frame_valid,
    output logic             sync_error
`ifdef SILIFE_SCAN_CAPTURE_STATS_EN
    ,
    output logic [15:0]      frame_count,
    output logic [7:0]       error_count
`endif
);

    typedef enum logic {S_SYNC, S_CAPT} state_t;

    state_t                        r_state;
    logic [IW-1:0]                 r_expected;
    logic [CW-1:0]                 r_cnt;
    logic [WIDTH-1:0]              r_prev_rows;
    logic [WIDTH-1:0][WIDTH-1:0]   r_shadow;
    logic [WIDTH-1:0][WIDTH-1:0]   r_front;
    logic                          r_frame_valid;
    logic                          r_sync_error;

    logic                          w_blank;
    logic                          w_multi;
    logic                          w_same;
    logic [CW-1:0]                 w_cnt_next;
    logic                          w_capture;
    logic [IW-1:0]                 w_idx;
    logic [WIDTH-1:0]              w_data;
    logic                          w_order_err;
    logic                          w_err;
    logic                          w_swap;

    localparam logic [CW-1:0]    STABLE = CW'(STABLE_CYCLES);
    localparam logic [IW-1:0]    LAST   = IW'(WIDTH - 1);

    assign w_blank = (rows == '0);
    // x & (x-1) clears the lowest set bit; anything left means multi-hot
    assign w_multi = !w_blank && ((rows & (rows - {{(WIDTH-1){1'b0}}, 1'b1})) != '0);
    // a dwell continues only while the counter is live (blank/multi zero it)
    assign w_same  = (rows == r_prev_rows) && (r_cnt != '0);
    assign w_data  = columns ^ {WIDTH{invert}};

    always_comb begin
        w_cnt_next = '0;
        if (w_blank || w_multi)
            w_cnt_next = '0;
        else if (!w_same)
            w_cnt_next = CW'(1);
        else if (r_cnt == STABLE)
            w_cnt_next = r_cnt;
        else
            w_cnt_next = r_cnt + CW'(1);
    end

    // capture exactly once per dwell: the edge the counter first hits STABLE
    assign w_capture = !w_blank && !w_multi && (w_cnt_next == STABLE) &&
                       (!w_same || (r_cnt != STABLE));

    always_comb begin
        w_idx = '0;
        for (int i = 0; i < WIDTH; i++)
            if (rows[i]) w_idx = IW'(i);
    end

    assign w_order_err = w_capture && (r_state == S_CAPT) && (w_idx != r_expected);
    assign w_err       = w_multi || w_order_err;
    assign w_swap      = w_capture && (r_state == S_CAPT) && (w_idx == r_expected) &&
                         (w_idx == LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= S_SYNC;
            r_expected    <= '0;
            r_cnt         <= '0;
            r_prev_rows   <= '0;
            r_shadow      <= '0;
            r_front       <= '0;
            r_frame_valid <= 1'b0;
            r_sync_error  <= 1'b0;
        end else begin
            r_prev_rows   <= rows;
            r_cnt         <= w_cnt_next;
            r_frame_valid <= w_swap;

            // a fresh error beats a simultaneous clear
            if (w_err)
                r_sync_error <= 1'b1;
            else if (clear_error)
                r_sync_error <= 1'b0;

            if (w_multi) begin
                // shadow content is abandoned; it is fully rewritten before any swap
                r_state    <= S_SYNC;
                r_expected <= '0;
            end else if (w_capture) begin
                case (r_state)
                    S_SYNC: begin
                        if (w_idx == '0) begin
                            r_shadow[0] <= w_data;
                            r_expected  <= IW'(1);
                            r_state     <= S_CAPT;
                        end
                    end
                    S_CAPT: begin
                        if (w_idx == r_expected) begin
                            if (w_idx == LAST) begin
                                for (int i = 0; i < WIDTH - 1; i++)
                                    r_front[i] <= r_shadow[i];
                                r_front[WIDTH-1] <= w_data;
                                r_expected       <= '0;
                            end else begin
                                r_shadow[w_idx] <= w_data;
                                r_expected      <= r_expected + IW'(1);
                            end
                        end else if (w_idx == '0) begin
                            // out of order, but row 0 is a valid frame start
                            r_shadow[0] <= w_data;
                            r_expected  <= IW'(1);
                        end else begin
                            r_state    <= S_SYNC;
                            r_expected <= '0;
                        end
                    end
                    default: r_state <= S_SYNC;
                endcase
            end
        end
    end

    assign read_cells  = r_front[read_row];
    assign frame_valid = r_frame_valid;
    assign sync_error  = r_sync_error;

`ifdef SILIFE_SCAN_CAPTURE_STATS_EN
    logic [15:0] r_frame_count;
    logic [7:0]  r_error_count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_frame_count <= '0;
            r_error_count <= '0;
        end else begin
            if (w_swap)
                r_frame_count <= r_frame_count + 16'd1;
            if (w_err && (r_error_count != 8'hFF))
                r_error_count <= r_error_count + 8'd1;
        end
    end

    assign frame_count = r_frame_count;
    assign error_count = r_error_count;
`endif

endmodule

// File: tb/tb_silife_scan_capture.sv
module tb_silife_scan_capture;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] rows = '0;
    logic [7:0] columns = '0;
    logic       invert = 1'b0;
    logic       clear_error = 1'b0;
    logic [2:0] read_row = '0;
    logic [7:0] read_cells;
    logic       frame_valid;
    logic       sync_error;
`ifdef SILIFE_SCAN_CAPTURE_STATS_EN
    logic [15:0] frame_count;
    logic [7:0]  error_count;
`endif

    silife_scan_capture #(.WIDTH(8), .STABLE_CYCLES(2)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .rows        (rows),
        .columns     (columns),
        .invert      (invert),
        .clear_error (clear_error),
        .read_row    (read_row),
        .read_cells  (read_cells),
        .frame_valid (frame_valid),
        .sync_error  (sync_error)
`ifdef SILIFE_SCAN_CAPTURE_STATS_EN
        ,
        .frame_count (frame_count),
        .error_count (error_count)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int fv_cnt = 0;
    int fv0;

    // reference: the frame the display should currently show, and the frame being scanned
    logic [7:0] exp_front [8];
    logic [7:0] mat [8];

    always @(negedge clk) if (frame_valid === 1'b1) fv_cnt++;

    initial begin
        #500000;
        $display("FAIL timeout: simulation ran past its time budget");
        $fatal(1);
    end

    task automatic put(input logic [7:0] r, input logic [7:0] c, input int n);
        rows = r;
        columns = c;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic rand_mat();
        for (int i = 0; i < 8; i++) mat[i] = 8'($urandom_range(0, 255));
    endtask

    // scan rows first..last of mat, each held for dwell cycles, optional blank gap
    task automatic scan(input int first, input int last, input int dwell,
                        input logic inv, input bit blank);
        invert = inv;
        for (int i = first; i <= last; i++) begin
            put(8'(1 << i), mat[i] ^ {8{inv}}, dwell);
            if (blank) put(8'h00, 8'($urandom), 1);
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 8; i++) exp_front[i] = '0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (frame_valid !== 1'b0) begin bad++; $display("FAIL reset_fv: got %b want 0", frame_valid); end
        total++;
        if (sync_error !== 1'b0) begin bad++; $display("FAIL reset_err: got %b want 0", sync_error); end
        reset_n = 1'b1;
        for (int r = 0; r < 8; r++) begin
            read_row = 3'(r); #1;
            total++;
            if (read_cells !== exp_front[r]) begin
                bad++; $display("FAIL reset_row%0d: got %h want %h", r, read_cells, exp_front[r]);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_clean();
        mat[0] = 8'h20; mat[1] = 8'h00; mat[2] = 8'h00; mat[3] = 8'h00;
        mat[4] = 8'h24; mat[5] = 8'h00; mat[6] = 8'h66; mat[7] = 8'haa;
        fv0 = fv_cnt;
        scan(0, 7, 3, 1'b0, 1'b0);
        total++;
        if (fv_cnt - fv0 !== 1) begin bad++; $display("FAIL clean_fv: got %0d pulses want 1", fv_cnt - fv0); end
        put(8'h00, 8'h00, 2);
        for (int i = 0; i < 8; i++) exp_front[i] = mat[i];
        total++;
        if (sync_error !== 1'b0) begin bad++; $display("FAIL clean_err: got %b want 0", sync_error); end
        for (int r = 0; r < 8; r++) begin
            read_row = 3'(r); #1;
            total++;
            if (read_cells !== exp_front[r]) begin
                bad++; $display("FAIL clean_row%0d: got %h want %h", r, read_cells, exp_front[r]);
            end
        end
    endtask

    task automatic test_invert();
        for (int k = 0; k < 3; k++) begin
            if (k > 0) rand_mat();
            fv0 = fv_cnt;
            scan(0, 7, (k == 0) ? 3 : int'($urandom_range(2, 4)), 1'b1, 1'b0);
            put(8'h00, 8'hFF, 2);
            invert = 1'b0;
            for (int i = 0; i < 8; i++) exp_front[i] = mat[i];
            total++;
            if (fv_cnt - fv0 !== 1) begin bad++; $display("FAIL inv_fv%0d: got %0d want 1", k, fv_cnt - fv0); end
            total++;
            if (sync_error !== 1'b0) begin bad++; $display("FAIL inv_err%0d: got %b want 0", k, sync_error); end
            for (int r = 0; r < 8; r++) begin
                read_row = 3'(r); #1;
                total++;
                if (read_cells !== exp_front[r]) begin
                    bad++; $display("FAIL inv%0d_row%0d: got %h want %h", k, r, read_cells, exp_front[r]);
                end
            end
        end
    endtask

    task automatic test_blank();
        rand_mat();
        fv0 = fv_cnt;
        scan(0, 7, 2, 1'b0, 1'b1);
        put(8'h00, 8'h00, 2);
        for (int i = 0; i < 8; i++) exp_front[i] = mat[i];
        total++;
        if (fv_cnt - fv0 !== 1) begin bad++; $display("FAIL blank_fv: got %0d want 1", fv_cnt - fv0); end
        total++;
        if (sync_error !== 1'b0) begin bad++; $display("FAIL blank_err: got %b want 0", sync_error); end
        // one-cycle dwells never reach the stability threshold
        rand_mat();
        fv0 = fv_cnt;
        scan(0, 7, 1, 1'b0, 1'b0);
        put(8'h00, 8'h00, 2);
        total++;
        if (fv_cnt - fv0 !== 0) begin bad++; $display("FAIL short_fv: got %0d want 0", fv_cnt - fv0); end
        total++;
        if (sync_error !== 1'b0) begin bad++; $display("FAIL short_err: got %b want 0", sync_error); end
        for (int r = 0; r < 8; r++) begin
            read_row = 3'(r); #1;
            total++;
            if (read_cells !== exp_front[r]) begin
                bad++; $display("FAIL blank_row%0d: got %h want %h", r, read_cells, exp_front[r]);
            end
        end
    endtask

    task automatic test_multihot();
        rand_mat();
        fv0 = fv_cnt;
        scan(0, 3, 2, 1'b0, 1'b0);
        put(8'h03, 8'h5A, 2);
        scan(4, 7, 2, 1'b0, 1'b0);
        put(8'h00, 8'h00, 2);
        total++;
        if (sync_error !== 1'b1) begin bad++; $display("FAIL mh_err: got %b want 1", sync_error); end
        total++;
        if (fv_cnt - fv0 !== 0) begin bad++; $display("FAIL mh_fv: got %0d want 0", fv_cnt - fv0); end
        for (int r = 0; r < 8; r++) begin
            read_row = 3'(r); #1;
            total++;
            if (read_cells !== exp_front[r]) begin
                bad++; $display("FAIL mh_keep_row%0d: got %h want %h", r, read_cells, exp_front[r]);
            end
        end
        clear_error = 1'b1;
        put(8'h00, 8'h00, 1);
        clear_error = 1'b0;
        total++;
        if (sync_error !== 1'b0) begin bad++; $display("FAIL mh_clear: got %b want 0", sync_error); end
        fv0 = fv_cnt;
        scan(0, 7, 2, 1'b0, 1'b0);
        put(8'h00, 8'h00, 2);
        for (int i = 0; i < 8; i++) exp_front[i] = mat[i];
        total++;
        if (fv_cnt - fv0 !== 1) begin bad++; $display("FAIL mh_next_fv: got %0d want 1", fv_cnt - fv0); end
        for (int r = 0; r < 8; r++) begin
            read_row = 3'(r); #1;
            total++;
            if (read_cells !== exp_front[r]) begin
                bad++; $display("FAIL mh_next_row%0d: got %h want %h", r, read_cells, exp_front[r]);
            end
        end
    endtask

    task automatic test_order();
        rand_mat();
        fv0 = fv_cnt;
        scan(0, 2, 2, 1'b0, 1'b0);
        scan(5, 7, 2, 1'b0, 1'b0);
        put(8'h00, 8'h00, 2);
        total++;
        if (sync_error !== 1'b1) begin bad++; $display("FAIL ord_err: got %b want 1", sync_error); end
        total++;
        if (fv_cnt - fv0 !== 0) begin bad++; $display("FAIL ord_fv: got %0d want 0", fv_cnt - fv0); end
        for (int r = 0; r < 8; r++) begin
            read_row = 3'(r); #1;
            total++;
            if (read_cells !== exp_front[r]) begin
                bad++; $display("FAIL ord_keep_row%0d: got %h want %h", r, read_cells, exp_front[r]);
            end
        end
        // error on the same edge as a clear keeps the flag set
        clear_error = 1'b1;
        put(8'h81, 8'h00, 1);
        clear_error = 1'b0;
        put(8'h00, 8'h00, 1);
        total++;
        if (sync_error !== 1'b1) begin bad++; $display("FAIL ord_err_wins: got %b want 1", sync_error); end
        clear_error = 1'b1;
        put(8'h00, 8'h00, 1);
        clear_error = 1'b0;
        // out-of-order jump back to row 0 restarts the frame on the same edge
        fv0 = fv_cnt;
        scan(0, 2, 2, 1'b0, 1'b0);
        rand_mat();
        scan(0, 7, 2, 1'b0, 1'b0);
        put(8'h00, 8'h00, 2);
        for (int i = 0; i < 8; i++) exp_front[i] = mat[i];
        total++;
        if (sync_error !== 1'b1) begin bad++; $display("FAIL restart_err: got %b want 1", sync_error); end
        total++;
        if (fv_cnt - fv0 !== 1) begin bad++; $display("FAIL restart_fv: got %0d want 1", fv_cnt - fv0); end
        for (int r = 0; r < 8; r++) begin
            read_row = 3'(r); #1;
            total++;
            if (read_cells !== exp_front[r]) begin
                bad++; $display("FAIL restart_row%0d: got %h want %h", r, read_cells, exp_front[r]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] first [8];
        rand_mat();
        for (int i = 0; i < 8; i++) first[i] = mat[i];
        fv0 = fv_cnt;
        scan(0, 7, 2, 1'b0, 1'b0);
        rand_mat();
        scan(0, 7, 2, 1'b0, 1'b0);
        put(8'h00, 8'h00, 2);
        for (int i = 0; i < 8; i++) exp_front[i] = mat[i];
        total++;
        if (fv_cnt - fv0 !== 2) begin bad++; $display("FAIL b2b_fv: got %0d want 2", fv_cnt - fv0); end
        for (int r = 0; r < 8; r++) begin
            read_row = 3'(r); #1;
            total++;
            if (read_cells !== exp_front[r]) begin
                bad++; $display("FAIL b2b_row%0d: got %h want %h (first frame %h)", r, read_cells, exp_front[r], first[r]);
            end
        end
    endtask

    task automatic test_reset_mid();
        put(8'h05, 8'h00, 1);
        put(8'h00, 8'h00, 1);
        rand_mat();
        scan(0, 2, 2, 1'b0, 1'b0);
        rows = 8'h08; columns = mat[3];
        @(posedge clk); #1;
        reset_n = 1'b0;
        #1;
        for (int i = 0; i < 8; i++) exp_front[i] = '0;
        total++;
        if (sync_error !== 1'b0) begin bad++; $display("FAIL rst_err: got %b want 0", sync_error); end
        total++;
        if (frame_valid !== 1'b0) begin bad++; $display("FAIL rst_fv: got %b want 0", frame_valid); end
`ifdef SILIFE_SCAN_CAPTURE_STATS_EN
        total++;
        if (frame_count !== 16'd0) begin bad++; $display("FAIL rst_fcnt: got %0d want 0", frame_count); end
`endif
        for (int r = 0; r < 8; r++) begin
            read_row = 3'(r); #1;
            total++;
            if (read_cells !== exp_front[r]) begin
                bad++; $display("FAIL rst_row%0d: got %h want %h", r, read_cells, exp_front[r]);
            end
        end
        @(posedge clk); #1;
        reset_n = 1'b1;
        put(8'h08, mat[3], 2);
        fv0 = fv_cnt;
        scan(4, 7, 2, 1'b0, 1'b0);
        put(8'h00, 8'h00, 2);
        total++;
        if (fv_cnt - fv0 !== 0) begin bad++; $display("FAIL rst_partial_fv: got %0d want 0", fv_cnt - fv0); end
        scan(0, 7, 2, 1'b0, 1'b0);
        put(8'h00, 8'h00, 2);
        for (int i = 0; i < 8; i++) exp_front[i] = mat[i];
        total++;
        if (fv_cnt - fv0 !== 1) begin bad++; $display("FAIL rst_full_fv: got %0d want 1", fv_cnt - fv0); end
`ifdef SILIFE_SCAN_CAPTURE_STATS_EN
        total++;
        if (frame_count !== 16'd1) begin bad++; $display("FAIL rst_fcnt1: got %0d want 1", frame_count); end
`endif
        for (int r = 0; r < 8; r++) begin
            read_row = 3'(r); #1;
            total++;
            if (read_cells !== exp_front[r]) begin
                bad++; $display("FAIL rst_full_row%0d: got %h want %h", r, read_cells, exp_front[r]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_clean();
        test_invert();
        test_blank();
        test_multihot();
        test_order();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
